// File: rtl/booth_pkg.sv
// Shared types and constants for the 32-bit Booth multiplier control path.
package booth_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_M = 3'd1,
      S_LOAD_Q = 3'd2,
      S_DECIDE = 3'd3,
      S_ADD    = 3'd4,
      S_SUB    = 3'd5,
      S_SHIFT  = 3'd6,
      S_DONE   = 3'd7
   } booth_state_t;

   localparam int         BOOTH_WIDTH    = 32;
   localparam logic [5:0] BOOTH_CNT_INIT = 6'd32;

endpackage

// File: rtl/booth_ctrl_decode.sv
// Pure Moore decoder: FSM state to datapath/counter strobes.
module booth_ctrl_decode
   import booth_pkg::*;
(
   input  logic [2:0] i_state,
   output logic       o_ld_m,
   output logic       o_ld_q,
   output logic       o_clr_a,
   output logic       o_clr_ff,
   output logic       o_ld_a,
   output logic       o_addsub,
   output logic       o_sft,
   output logic       o_ld_cnt,
   output logic       o_dec_cnt,
   output logic       o_done
);

   booth_state_t w_state;
   assign w_state = booth_state_t'(i_state);

   always_comb begin
      o_ld_m    = 1'b0;
      o_ld_q    = 1'b0;
      o_clr_a   = 1'b0;
      o_clr_ff  = 1'b0;
      o_ld_a    = 1'b0;
      o_addsub  = 1'b0;
      o_sft     = 1'b0;
      o_ld_cnt  = 1'b0;
      o_dec_cnt = 1'b0;
      o_done    = 1'b0;
      case (w_state)
         S_LOAD_M: begin
            o_ld_m   = 1'b1;
            o_clr_a  = 1'b1;
            o_clr_ff = 1'b1;
            o_ld_cnt = 1'b1;
         end
         S_LOAD_Q: o_ld_q = 1'b1;
         S_ADD: begin
            o_ld_a   = 1'b1;
            o_addsub = 1'b1;
         end
         S_SUB:    o_ld_a = 1'b1;
         S_SHIFT: begin
            o_sft     = 1'b1;
            o_dec_cnt = 1'b1;
         end
         S_DONE:   o_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/booth_controller.sv
// Booth multiplier control FSM; strobes are decoded from the state register only.
// Optional abort input enabled by defining BOOTH_CTRL_ABORT_EN.
module booth_controller
   import booth_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
`ifdef BOOTH_CTRL_ABORT_EN
   input  logic abort,
`endif
   input  logic q0,
   input  logic qm1,
   input  logic eqz,
   output logic ld_m,
   output logic ld_q,
   output logic clr_a,
   output logic clr_ff,
   output logic ld_a,
   output logic addsub,
   output logic sft,
   output logic ld_cnt,
   output logic dec_cnt,
   output logic done
);

   booth_state_t r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
`ifdef BOOTH_CTRL_ABORT_EN
      end else if (abort && r_state != S_IDLE) begin
         r_state <= S_IDLE;
`endif
      end else begin
         case (r_state)
            S_IDLE:   if (start) r_state <= S_LOAD_M;
            S_LOAD_M: r_state <= S_LOAD_Q;
            S_LOAD_Q: r_state <= S_DECIDE;
            // eqz is only meaningful here, after the SHIFT decrement has landed
            S_DECIDE: begin
               if (eqz)               r_state <= S_DONE;
               else if (!q0 && qm1)   r_state <= S_ADD;
               else if (q0 && !qm1)   r_state <= S_SUB;
               else                   r_state <= S_SHIFT;
            end
            S_ADD:    r_state <= S_SHIFT;
            S_SUB:    r_state <= S_SHIFT;
            S_SHIFT:  r_state <= S_DECIDE;
            S_DONE:   if (!start) r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   booth_ctrl_decode u_decode (
      .i_state   (r_state),
      .o_ld_m    (ld_m),
      .o_ld_q    (ld_q),
      .o_clr_a   (clr_a),
      .o_clr_ff  (clr_ff),
      .o_ld_a    (ld_a),
      .o_addsub  (addsub),
      .o_sft     (sft),
      .o_ld_cnt  (ld_cnt),
      .o_dec_cnt (dec_cnt),
      .o_done    (done)
   );

endmodule

// File: doc/booth_controller.md
# booth_controller

Control-path FSM for the 32-bit Booth multiplier. It sequences the datapath load, add/subtract and arithmetic-shift operations. It drives the 6-bit iteration counter's load and decrement strobes and consumes the counter's zero flag. It sits between the top-level start/done handshake and the datapath registers (A, Q, M, Q[-1] flip-flop) plus the iteration counter.

## Interface
Parameters: none; operand width fixed at 32, counter preload fixed at 32.

Ports:
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a multiply; level-sampled in IDLE
- q0  input  1  datapath Q[0]
- qm1  input  1  datapath Q[-1] flip-flop
- eqz  input  1  counter zero flag (count == 0)
- ld_m  output  1  load multiplicand register M
- ld_q  output  1  load multiplier into Q
- clr_a  output  1  clear accumulator A
- clr_ff  output  1  clear Q[-1] flip-flop
- ld_a  output  1  load ALU result into A
- addsub  output  1  ALU op: 1 = A+M, 0 = A-M
- sft  output  1  arithmetic right shift of {A,Q,Q[-1]}
- ld_cnt  output  1  counter preload to 32
- dec_cnt  output  1  counter decrement
- done  output  1  product valid in {A,Q}

## Operation
- States, 3-bit encoding: IDLE, LOAD_M, LOAD_Q, DECIDE, ADD, SUB, SHIFT, DONE. Outputs are Moore-decoded from state only.
- IDLE: all outputs 0. start=1 → LOAD_M.
- LOAD_M: ld_m, clr_a, clr_ff, ld_cnt = 1 → LOAD_Q.
- LOAD_Q: ld_q = 1 → DECIDE.
- DECIDE: no outputs. Transitions evaluated in priority order:
  - eqz=1 → DONE
  - else {q0,qm1}=01 → ADD
  - else {q0,qm1}=10 → SUB
  - else (00 or 11) → SHIFT
- ADD: ld_a=1, addsub=1 → SHIFT.
- SUB: ld_a=1, addsub=0 → SHIFT.
- SHIFT: sft=1, dec_cnt=1 → DECIDE.
- DONE: done=1. Stays while start=1; start=0 → IDLE. A held start never retriggers a multiply.
- addsub is 0 in every state except ADD.
- Exactly 32 SHIFT visits per multiply. Counter runs 32→0, and eqz is tested only in DECIDE, after the decrement has landed.
- rst=1 at any clock edge → IDLE next cycle, all outputs 0, regardless of state. The counter has no reset; it is harmless because IDLE never asserts dec_cnt.

## Timing
- Reset value of every output: 0. Reset state: IDLE.
- Let E0 be the edge where start=1 is sampled in IDLE. LOAD_M occupies E0..E1 and LOAD_Q occupies E1..E2.
- done rises at edge E0 + 67 + N, where N is the number of ADD/SUB visits (0..32).
- Each ALU operation costs 1 cycle; each bit costs DECIDE + SHIFT (2 cycles).
- No combinational path from any input to any output.

## Configuration
- Macro: BOOTH_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit, after start in the port list).
  - abort=1 in any state other than IDLE → IDLE next edge; outputs 0 that cycle onward.
  - rst has priority over abort.
  - Datapath contents after an abort are undefined.
- Undefined: no abort port; behaviour exactly as above.

## Structure
- Shared package booth_pkg holds:
  - state enum type booth_state_t
  - constant BOOTH_WIDTH = 32
  - constant BOOTH_CNT_INIT = 6'd32 (the counter uses it too)
- One natural sub-module: booth_ctrl_decode, a pure state → output-strobe decoder. The next-state logic and state register stay in booth_controller.

## Test plan
- Q=0, any M; start pulse → 0 ADD/SUB visits, 32 SHIFTs, done at E0+67, product 0.
- Q=32'hFFFFFFFF, M=5 → exactly one SUB (first bit), no ADD, done at E0+68, product -5.
- Q=1, M=7 → SUB then ADD on bits 0/1, done at E0+69, {A,Q}=7.
- rst asserted during the 10th SHIFT → next cycle IDLE, all outputs 0; subsequent start runs a full multiply correctly.
- start held high through completion → remains in DONE with done=1. start low → IDLE next edge. start high again → LOAD_M asserts ld_cnt.
- With BOOTH_CTRL_ABORT_EN, abort in ADD → IDLE next edge, ld_a deasserted. abort and rst together → reset behaviour.
